// File: rtl/score_bcd_converter.sv
// Binary score to packed BCD converter for the seven-segment score display.
// Serial double-dabble, one bit per clock; leading zero digits are blanked.
//
// state      | meaning
// ST_IDLE    | waiting for start, last result held on bcd_out/digit_en
// ST_CONVERT | BIN_W add-3/shift iterations on {scratch, shift}
// ST_DONE    | one-cycle done pulse, start ignored
module score_bcd_converter #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     digit_en
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int SC_W  = 4 * DIGITS;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CONVERT, ST_DONE} state_t;

  state_t            state_q;
  logic [BIN_W-1:0]  shift_q, shift_d;
  logic [SC_W-1:0]   scratch_q, scratch_d, adj;
  logic [CNT_W-1:0]  cnt_q;
  logic [SC_W-1:0]   bcd_q;
  logic [DIGITS-1:0] den_q, den_d;
  logic              busy_q, done_q;
  logic              any_nz;

  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
    {scratch_d, shift_d} = {adj, shift_q} << 1;
  end

  // Blanking walks down from the top digit; the units digit is always lit.
  always_comb begin
    any_nz = 1'b0;
    den_d  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      any_nz   = any_nz | (|scratch_d[4*i +: 4]);
      den_d[i] = any_nz;
    end
    den_d[0] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      den_q     <= DIGITS'(1);
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            shift_q   <= bin_in;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          shift_q   <= shift_d;
          scratch_q <= scratch_d;
          cnt_q     <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            bcd_q   <= scratch_d;
            den_q   <= den_d;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign digit_en = den_q;

endmodule
